// File: rtl/ldpc_enc_sched_if.sv
// ldpc_enc_sched_if: channel-side and encoder-side signals of the two-channel LDPC encoder scheduler.
interface ldpc_enc_sched_if;
    logic       req0, req1;
    logic [4:0] modcod0, modcod1;
    logic [7:0] din0, din1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       enc_rdy;
    logic       enc_sof;
    logic [4:0] enc_modcod;
    logic [7:0] enc_din;
    logic       enc_din_valid;
    logic       grant_id, busy, frame_done, modcod_err, timeout_err;

    modport slave (
        input  req0, req1, modcod0, modcod1, din0, din1, valid0, valid1, enc_rdy,
        output ready0, ready1, enc_sof, enc_modcod, enc_din, enc_din_valid,
        output grant_id, busy, frame_done, modcod_err, timeout_err
    );

    modport master (
        output req0, req1, modcod0, modcod1, din0, din1, valid0, valid1, enc_rdy,
        input  ready0, ready1, enc_sof, enc_modcod, enc_din, enc_din_valid,
        input  grant_id, busy, frame_done, modcod_err, timeout_err
    );
endinterface

// File: rtl/ldpc_enc_sched.sv
// ldpc_enc_sched: round-robin two-channel frame scheduler feeding one LDPC encoder.
module ldpc_enc_sched #(
    parameter int DONE_TIMEOUT = 65535
) (
    input logic             clk,
    input logic             srst_n,
    ldpc_enc_sched_if.slave bus
);
    localparam int TW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SOF, FEED, WAIT_DONE} state_t;

    state_t        state, state_nx;
    logic          last_grant, sel, sel_bad, mc_bad, rdy_seen_low;
    logic          start, vld, acc, last_byte, done, tmo;
    logic [4:0]    sel_mc;
    logic [7:0]    din;
    logic [12:0]   sel_len, len, cnt;
    logic [TW-1:0] wcnt;

    // On contention the channel that did not win last time gets the grant
    assign sel     = bus.req0 && bus.req1 ? ~last_grant : bus.req1;
    assign sel_mc  = sel ? bus.modcod1 : bus.modcod0;
    assign sel_bad = sel_mc == 5'd0 || sel_mc > 5'd28;

    always_comb begin
        case (sel_mc)
            5'd2:                      sel_len = 13'd2700;
            5'd3:                      sel_len = 13'd3240;
            5'd4:                      sel_len = 13'd4050;
            5'd5, 5'd12:               sel_len = 13'd4860;
            5'd6, 5'd13, 5'd18:        sel_len = 13'd5400;
            5'd7, 5'd14, 5'd19, 5'd24: sel_len = 13'd6075;
            5'd8, 5'd20, 5'd25:        sel_len = 13'd6480;
            5'd9, 5'd15, 5'd21, 5'd26: sel_len = 13'd6750;
            5'd10, 5'd16, 5'd22, 5'd27: sel_len = 13'd7200;
            5'd11, 5'd17, 5'd23, 5'd28: sel_len = 13'd7290;
            default:                   sel_len = 13'd2025;
        endcase
    end

    assign vld       = bus.grant_id ? bus.valid1 : bus.valid0;
    assign din       = bus.grant_id ? bus.din1 : bus.din0;
    assign start     = state == IDLE && bus.enc_rdy && (bus.req0 || bus.req1);
    assign acc       = state == FEED && vld;
    assign last_byte = acc && cnt == len - 13'd1;
    assign done      = state == WAIT_DONE && rdy_seen_low && bus.enc_rdy;
    assign tmo       = state == WAIT_DONE && !done && wcnt == TW'(DONE_TIMEOUT);

    always_comb begin
        state_nx        = state;
        bus.enc_sof     = state == SOF;
        bus.busy        = state != IDLE;
        bus.ready0      = state == FEED && !bus.grant_id;
        bus.ready1      = state == FEED && bus.grant_id;
        bus.frame_done  = done;
        bus.modcod_err  = state == SOF && mc_bad;
        bus.timeout_err = tmo;
        case (state)
            IDLE:      state_nx = start ? SOF : IDLE;
            SOF:       state_nx = FEED;
            FEED:      state_nx = last_byte ? WAIT_DONE : FEED;
            WAIT_DONE: state_nx = done || tmo ? IDLE : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state             <= IDLE;
            last_grant        <= 1'b1;
            bus.grant_id      <= 1'b0;
            bus.enc_modcod    <= 5'd0;
            len               <= 13'd2025;
            mc_bad            <= 1'b0;
            cnt               <= 13'd0;
            wcnt              <= '0;
            rdy_seen_low      <= 1'b0;
            bus.enc_din       <= 8'd0;
            bus.enc_din_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                last_grant     <= sel;
                bus.grant_id   <= sel;
                bus.enc_modcod <= sel_mc;
                len            <= sel_len;
                mc_bad         <= sel_bad;
            end
            cnt               <= state == SOF ? 13'd0 : cnt + 13'(acc);
            wcnt              <= state == WAIT_DONE ? wcnt + 1'b1 : '0;
            rdy_seen_low      <= state == SOF ? 1'b0 : rdy_seen_low | !bus.enc_rdy;
            bus.enc_din_valid <= acc;
            if (acc)
                bus.enc_din <= din;
        end
    end
endmodule

// File: tb/tb_ldpc_enc_sched.sv
// tb_ldpc_enc_sched: directed scenario tests for the two-channel LDPC encoder scheduler.
module tb_ldpc_enc_sched;
    logic clk = 1'b0;
    logic srst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    typedef struct {
        int rx;
        int lat;
        int ord;
        int oth;
        int bsy;
        int pul;
        bit to;
    } fres_t;

    ldpc_enc_sched_if bus ();
    ldpc_enc_sched #(.DONE_TIMEOUT(100)) dut (.clk(clk), .srst_n(srst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of run want end of run");
        $fatal(1);
    end

    function automatic logic [7:0] pat(input logic g, input int k);
        return 8'(k) ^ 8'(k >> 8) ^ {g, 7'b0};
    endfunction

    task automatic wait_sof(output bit seen, output logic gid, output logic [4:0] mc,
                            output logic err, output logic side);
        seen = 0; gid = 0; mc = 0; err = 0; side = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.enc_sof === 1'b1) begin
                seen = 1;
                gid  = bus.grant_id;
                mc   = bus.enc_modcod;
                err  = bus.modcod_err;
                side = bus.enc_din_valid | bus.ready0 | bus.ready1 | !bus.busy;
                return;
            end
        end
    endtask

    // Entered at the negedge of the SOF cycle; leaves at the first WAIT_DONE negedge
    task automatic feed_frame(input logic g, input bit rnd, input int stop_rx, output fres_t r);
        bit   acc, v;
        logic rdy, oth;
        int   sent;
        r = '{default: 0};
        acc = 0;
        sent = 0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (bus.enc_din_valid !== logic'(acc)) r.lat++;
            if (bus.enc_din_valid === 1'b1) begin
                if (bus.enc_din !== pat(g, r.rx)) r.ord++;
                r.rx++;
            end
            rdy = g ? bus.ready1 : bus.ready0;
            oth = g ? bus.ready0 : bus.ready1;
            if (oth !== 1'b0) r.oth++;
            if (bus.busy !== 1'b1) r.bsy++;
            if ({bus.enc_sof, bus.frame_done, bus.modcod_err, bus.timeout_err} !== 4'd0) r.pul++;
            if (stop_rx > 0 && r.rx == stop_rx) return;
            if (rdy !== 1'b1 && sent > 0) return;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (g) begin bus.din1 = pat(g, sent); bus.valid1 = v; end
            else   begin bus.din0 = pat(g, sent); bus.valid0 = v; end
            acc = v && rdy === 1'b1;
            sent += int'(acc);
        end
        r.to = 1;
    endtask

    task automatic finish_frame(output bit done);
        done = 0;
        bus.enc_rdy = 1'b0;
        @(negedge clk);
        bus.enc_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.frame_done === 1'b1) begin done = 1; return; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bus.req0 = 1'b1; bus.req1 = 1'b0; bus.modcod0 = 5'd4; bus.modcod1 = 5'd4;
        bus.din0 = 8'd0; bus.din1 = 8'd0; bus.valid0 = 1'b1; bus.valid1 = 1'b1;
        bus.enc_rdy = 1'b1;
        srst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.enc_sof, bus.enc_din_valid, bus.enc_din, bus.enc_modcod, bus.ready0, bus.ready1,
             bus.grant_id, bus.busy, bus.frame_done, bus.modcod_err, bus.timeout_err} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {bus.enc_sof, bus.enc_din_valid, bus.enc_din,
                     bus.enc_modcod, bus.ready0, bus.ready1, bus.grant_id, bus.busy, bus.frame_done,
                     bus.modcod_err, bus.timeout_err});
        end
        bus.enc_rdy = 1'b0;
        srst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold_enc_rdy_low: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_contention;
        bit seen, d;
        logic gid, err, side;
        logic [4:0] mc;
        fres_t r;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.modcod0 = 5'd11; bus.modcod1 = 5'd11;
        bus.valid0 = 1'b1; bus.valid1 = 1'b1; bus.enc_rdy = 1'b1;
        for (int f = 0; f < 4; f++) begin
            wait_sof(seen, gid, mc, err, side);
            n_cmp++;
            if ({seen, gid, mc, err, side} !== {1'b1, 1'(f), 5'd11, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL contention_sof%0d: got seen=%b gid=%b mc=%0d err=%b side=%b want 1 %0d 11 0 0",
                         f, seen, gid, mc, err, side, f % 2);
            end
            feed_frame(1'(f), 0, 0, r);
            n_cmp++;
            if (r.rx !== 7290 || (r.lat | r.ord | r.oth | r.bsy | r.pul | int'(r.to)) != 0) begin
                n_err++;
                $display("FAIL contention_feed%0d: got rx=%0d lat=%0d ord=%0d oth=%0d bsy=%0d pul=%0d to=%0d want rx=7290 rest 0",
                         f, r.rx, r.lat, r.ord, r.oth, r.bsy, r.pul, r.to);
            end
            finish_frame(d);
            @(negedge clk);
            n_cmp++;
            if ({d, bus.busy} !== 2'b10) begin
                n_err++;
                $display("FAIL contention_done%0d: got done=%b busy_after=%b want 1 0", f, d, bus.busy);
            end
        end
    endtask

    task automatic test_single_frame;
        bit seen, d;
        logic gid, err, side;
        logic [4:0] mc;
        fres_t r;
        bus.req0 = 1'b1; bus.req1 = 1'b0; bus.modcod0 = 5'd4; bus.valid0 = 1'b1; bus.enc_rdy = 1'b1;
        wait_sof(seen, gid, mc, err, side);
        n_cmp++;
        if ({seen, gid, mc, err, side} !== {1'b1, 1'b0, 5'd4, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL single_sof: got seen=%b gid=%b mc=%0d err=%b side=%b want 1 0 4 0 0",
                     seen, gid, mc, err, side);
        end
        bus.req0 = 1'b0;
        bus.modcod0 = 5'd9;
        feed_frame(1'b0, 0, 0, r);
        n_cmp++;
        if (r.rx !== 4050 || (r.lat | r.ord | r.oth | r.bsy | r.pul | int'(r.to)) != 0) begin
            n_err++;
            $display("FAIL single_feed: got rx=%0d lat=%0d ord=%0d oth=%0d bsy=%0d pul=%0d to=%0d want rx=4050 rest 0",
                     r.rx, r.lat, r.ord, r.oth, r.bsy, r.pul, r.to);
        end
        finish_frame(d);
        @(negedge clk);
        n_cmp++;
        if ({d, bus.busy, bus.enc_modcod} !== {1'b1, 1'b0, 5'd4}) begin
            n_err++;
            $display("FAIL single_done: got done=%b busy=%b modcod=%0d want 1 0 4", d, bus.busy, bus.enc_modcod);
        end
    endtask

    task automatic test_bad_modcod;
        bit seen, d;
        logic gid, err, side;
        logic [4:0] mc;
        fres_t r;
        bus.req0 = 1'b0; bus.req1 = 1'b1; bus.modcod1 = 5'd30; bus.valid1 = 1'b1;
        wait_sof(seen, gid, mc, err, side);
        n_cmp++;
        if ({seen, gid, mc, err, side} !== {1'b1, 1'b1, 5'd30, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL bad_modcod_sof: got seen=%b gid=%b mc=%0d err=%b side=%b want 1 1 30 1 0",
                     seen, gid, mc, err, side);
        end
        bus.req1 = 1'b0;
        feed_frame(1'b1, 0, 0, r);
        n_cmp++;
        if (r.rx !== 2025 || (r.lat | r.ord | r.oth | r.bsy | r.pul | int'(r.to)) != 0) begin
            n_err++;
            $display("FAIL bad_modcod_feed: got rx=%0d lat=%0d ord=%0d oth=%0d bsy=%0d pul=%0d to=%0d want rx=2025 rest 0",
                     r.rx, r.lat, r.ord, r.oth, r.bsy, r.pul, r.to);
        end
        finish_frame(d);
        n_cmp++;
        if (d !== 1'b1) begin
            n_err++;
            $display("FAIL bad_modcod_done: got %b want 1", d);
        end
    endtask

    task automatic test_backpressure;
        bit seen, d;
        logic gid, err, side;
        logic [4:0] mc;
        fres_t r;
        @(negedge clk);
        bus.req0 = 1'b1; bus.modcod0 = 5'd9;
        wait_sof(seen, gid, mc, err, side);
        n_cmp++;
        if ({seen, gid, mc, err, side} !== {1'b1, 1'b0, 5'd9, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL backpressure_sof: got seen=%b gid=%b mc=%0d err=%b side=%b want 1 0 9 0 0",
                     seen, gid, mc, err, side);
        end
        bus.req0 = 1'b0;
        feed_frame(1'b0, 1, 0, r);
        n_cmp++;
        if ({r.rx, bus.ready0} !== {32'd6750, 1'b0} || (r.lat | r.ord | r.oth | r.bsy | r.pul | int'(r.to)) != 0) begin
            n_err++;
            $display("FAIL backpressure_feed: got rx=%0d ready0=%b lat=%0d ord=%0d oth=%0d bsy=%0d pul=%0d to=%0d want rx=6750 ready0=0 rest 0",
                     r.rx, bus.ready0, r.lat, r.ord, r.oth, r.bsy, r.pul, r.to);
        end
        finish_frame(d);
    endtask

    task automatic test_timeout;
        bit seen, got, fd;
        logic gid, err, side;
        logic [4:0] mc;
        int k;
        fres_t r;
        @(negedge clk);
        bus.req0 = 1'b1; bus.modcod0 = 5'd1; bus.valid0 = 1'b1;
        wait_sof(seen, gid, mc, err, side);
        bus.req0 = 1'b0;
        feed_frame(1'b0, 0, 0, r);
        n_cmp++;
        if (r.rx !== 2025 || !seen) begin
            n_err++;
            $display("FAIL timeout_feed: got rx=%0d sof=%b want 2025 1", r.rx, seen);
        end
        bus.enc_rdy = 1'b0;
        got = 0; fd = 0; k = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.frame_done === 1'b1) fd = 1;
            if (bus.timeout_err === 1'b1) begin got = 1; k = i; break; end
            @(negedge clk);
        end
        n_cmp++;
        if ({got, fd} !== 2'b10 || k !== 100) begin
            n_err++;
            $display("FAIL timeout_pulse: got seen=%b cycle=%0d frame_done=%b want 1 100 0", got, k, fd);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.busy, bus.timeout_err, bus.frame_done} !== 3'b000) begin
            n_err++;
            $display("FAIL timeout_idle: got busy=%b to=%b fd=%b want 0 0 0", bus.busy, bus.timeout_err, bus.frame_done);
        end
        bus.enc_rdy = 1'b1;
    endtask

    task automatic test_reset_mid_frame;
        bit seen;
        logic gid, err, side;
        logic [4:0] mc;
        fres_t r;
        @(negedge clk);
        bus.req0 = 1'b1; bus.req1 = 1'b0; bus.modcod0 = 5'd2; bus.valid0 = 1'b1; bus.enc_rdy = 1'b1;
        wait_sof(seen, gid, mc, err, side);
        bus.req0 = 1'b0;
        feed_frame(1'b0, 0, 1000, r);
        n_cmp++;
        if ({seen, gid, mc} !== {1'b1, 1'b0, 5'd2} || r.rx !== 1000 || r.lat != 0 || r.ord != 0) begin
            n_err++;
            $display("FAIL midframe_feed: got sof=%b gid=%b mc=%0d rx=%0d lat=%0d ord=%0d want 1 0 2 1000 0 0",
                     seen, gid, mc, r.rx, r.lat, r.ord);
        end
        srst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.enc_sof, bus.enc_din_valid, bus.enc_din, bus.enc_modcod, bus.ready0, bus.ready1,
             bus.grant_id, bus.busy, bus.frame_done, bus.modcod_err, bus.timeout_err} !== 22'd0) begin
            n_err++;
            $display("FAIL midframe_reset_outputs: got %h want 0", {bus.enc_sof, bus.enc_din_valid, bus.enc_din,
                     bus.enc_modcod, bus.ready0, bus.ready1, bus.grant_id, bus.busy, bus.frame_done,
                     bus.modcod_err, bus.timeout_err});
        end
        srst_n = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.modcod0 = 5'd3; bus.modcod1 = 5'd3;
        wait_sof(seen, gid, mc, err, side);
        n_cmp++;
        if ({seen, gid, mc, err} !== {1'b1, 1'b0, 5'd3, 1'b0}) begin
            n_err++;
            $display("FAIL midframe_regrant: got seen=%b gid=%b mc=%0d err=%b want 1 0 3 0", seen, gid, mc, err);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_frame();
        test_bad_modcod();
        test_backpressure();
        test_timeout();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ldpc_enc_sched.md
LDPC_ENC_SCHED -- requirements
Module: ldpc_enc_sched

Interface
REQ-001 The block SHALL have parameter DONE_TIMEOUT, default 65535, giving the maximum cycles in WAIT_DONE before an abort.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port srst_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have ports req0/req1, input, 1 each: channel g has a frame pending.
REQ-005 The block SHALL have ports modcod0/modcod1, input, 5 each: MODCOD of channel g's pending frame.
REQ-006 The block SHALL have ports din0/din1, input, 8 each, and valid0/valid1, input, 1 each: channel g info-byte stream.
REQ-007 The block SHALL have ports ready0/ready1, output, 1 each: byte accepted on cycles where valid_g && ready_g.
REQ-008 The block SHALL have port enc_rdy, input, 1: encoder idle and waiting for SOF.
REQ-009 The block SHALL have ports enc_sof (output, 1), enc_modcod (output, 5), enc_din (output, 8) and enc_din_valid (output, 1): encoder drive.
REQ-010 The block SHALL have ports grant_id (output, 1), busy (output, 1), frame_done (output, 1, pulse), modcod_err (output, 1, pulse) and timeout_err (output, 1, pulse).

Function
REQ-011 The FSM SHALL have the states IDLE, SOF, FEED and WAIT_DONE.
REQ-012 IDLE -> SOF SHALL occur when enc_rdy=1 and (req0|req1); the block latches grant_id, modcod and len on that edge.
- Only req1 set: grant 1. Only req0 set: grant 0.
- Both set: grant = ~last_grant (round-robin). last_grant updates on every grant.
REQ-013 SOF SHALL last exactly 1 cycle, with enc_sof=1, enc_din_valid=0 and enc_modcod = the latched value; SOF -> FEED unconditionally.
REQ-014 enc_modcod SHALL hold the latched value from SOF until the next grant.
REQ-015 len (bytes) SHALL be set from the latched MODCOD: 1->2025, 2->2700, 3->3240, 4->4050, {5,12}->4860, {6,13,18}->5400, {7,14,19,24}->6075, {8,20,25}->6480, {9,15,21,26}->6750, {10,16,22,27}->7200, {11,17,23,28}->7290.
REQ-016 MODCOD 0 or 29..31 SHALL use len 2025 (rate 1/4), with modcod_err pulsed for 1 cycle in the SOF cycle.
REQ-017 In FEED, ready_g SHALL be 1 only for the granted channel; ready of the other channel SHALL be 0 in every state.
REQ-018 Each accepted byte SHALL appear on enc_din with enc_din_valid=1 exactly 1 cycle later; enc_din_valid=0 on all other cycles, and bytes keep their order.
REQ-019 A 13-bit byte counter SHALL clear in SOF and increment per accepted byte.
REQ-020 When the accepted byte has count == len-1, ready SHALL drop the next cycle and the FSM SHALL go FEED -> WAIT_DONE; no byte beyond len is accepted.
REQ-021 A valid_g gap in FEED SHALL stall the block with no timeout; the counter holds.
REQ-022 A flag rdy_seen_low SHALL clear in SOF and set on any cycle with enc_rdy=0 after SOF.
REQ-023 WAIT_DONE -> IDLE with frame_done=1 for 1 cycle SHALL occur when rdy_seen_low=1 and enc_rdy=1.
REQ-024 A WAIT_DONE cycle counter SHALL start at 0; on reaching DONE_TIMEOUT without completion, the block pulses timeout_err for 1 cycle, goes to IDLE and does not pulse frame_done.
REQ-025 A new grant SHALL NOT occur in the same cycle as frame_done; IDLE is held at least 1 cycle.
REQ-026 busy SHALL be 1 in SOF, FEED and WAIT_DONE, and 0 in IDLE.
REQ-027 A req change after grant SHALL be ignored until the next IDLE.
REQ-028 A modcod_g change after grant SHALL be ignored until the next IDLE.
REQ-029 In IDLE with enc_rdy=0, the block SHALL stay in IDLE regardless of req.

Reset
REQ-030 srst_n=0 at a clock edge SHALL force state IDLE, last_grant=1 (channel 0 wins the first contention), counters 0 and rdy_seen_low=0.
REQ-031 The same edge SHALL force enc_sof=0, enc_din_valid=0, enc_din=0, enc_modcod=0, ready0=ready1=0, grant_id=0, busy=0, frame_done=0, modcod_err=0 and timeout_err=0.
REQ-032 Reset asserted mid-FEED or mid-WAIT_DONE SHALL abort the frame with no frame_done; the block resumes from IDLE the cycle after srst_n=1.

Verification
REQ-033 Single frame: req0=1, modcod0=4, enc_rdy=1, valid0 always 1 -> one enc_sof pulse with enc_modcod=4, then exactly 4050 enc_din_valid cycles in order, then busy=1 until enc_rdy 0->1, then frame_done pulse.
REQ-034 Contention: req0=req1=1 continuously, modcod 11 on both -> grants alternate 0,1,0,1; each frame carries 7290 bytes; no interleaving of channel bytes.
REQ-035 Invalid MODCOD: modcod1=30 -> modcod_err pulse in the SOF cycle, 2025 bytes forwarded, enc_modcod=30.
REQ-036 Backpressure: valid0 toggled randomly at 50% on modcod 9 -> exactly 6750 bytes with 1-cycle latency each, and ready0 drops after the last byte.
REQ-037 Timeout: DONE_TIMEOUT=100, enc_rdy held 0 after feed -> timeout_err at WAIT_DONE cycle 100, no frame_done, return to IDLE.
REQ-038 Reset mid-frame: srst_n=0 after byte 1000 of a modcod-2 frame -> all outputs 0 the next cycle; the next contention is granted to channel 0.
